// File: rtl/servo_pkg.sv
// Purpose: shared types, widths and defaults for the servo command scheduler.
// Latency: n/a (declarations and a combinational clamp helper only).
// Backpressure: n/a.
package servo_pkg;

    localparam int WORDSIZE = 15;
    localparam int NUM_CH   = 8;

    localparam logic [WORDSIZE-1:0] NEUTRAL_DEF   = 15'd1500;
    localparam logic [WORDSIZE-1:0] WIDTH_MIN_DEF = 15'd900;
    localparam logic [WORDSIZE-1:0] WIDTH_MAX_DEF = 15'd2100;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COLLECT_A = 2'd1,
        COLLECT_B = 2'd2,
        COMMIT    = 2'd3
    } sched_state_t;

    typedef enum logic {
        SRC_A = 1'b0,
        SRC_B = 1'b1
    } src_t;

    // Unsigned clamp of a requested width into [lo, hi].
    function automatic logic [WORDSIZE-1:0] clamp_width(
        input logic [WORDSIZE-1:0] w,
        input logic [WORDSIZE-1:0] lo,
        input logic [WORDSIZE-1:0] hi
    );
        if (w < lo) begin
            return lo;
        end else if (w > hi) begin
            return hi;
        end
        return w;
    endfunction

endpackage

// File: rtl/src_watchdog.sv
// Purpose: per-source liveness timer; healthy while the down-counter is non-zero.
// Latency: reload is visible on healthy the clk after it is asserted.
// Backpressure: none; reload wins over a same-clk tick decrement.
//
// Ports: clk, rst (sync, active-high), tick_1us (1 us strobe),
//        reload (good frame seen), healthy (counter != 0).
module src_watchdog #(
    parameter int TIMEOUT = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_1us,
    input  logic reload,
    output logic healthy
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    // Reset leaves the counter expired so a source must prove itself first.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (reload) begin
            cnt <= CW'(TIMEOUT);
        end else if (tick_1us && (cnt != '0)) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign healthy = (cnt != '0);

endmodule

// File: rtl/servo_cmd_sched.sv
// Purpose: collects 8-channel width frames from sources A/B, clamps, commits whole frames, fails over / to neutral.
// Latency: 2 clk from accepting the last word of a good frame to widths + data_update_flag.
// Backpressure: ready low for the non-locked source during a frame and for both during COMMIT; A wins ties in IDLE.
//
// Ports: clk, rst (sync, active-high), tick_1us; a_*/b_* valid-ready word streams (ch, width, last);
//        pulse_width_ch1..8 + data_update_flag to the PWM; active_src, failsafe, frame_err_cnt status.
module servo_cmd_sched
    import servo_pkg::*;
#(
    parameter logic [WORDSIZE-1:0] WIDTH_MIN     = WIDTH_MIN_DEF,
    parameter logic [WORDSIZE-1:0] WIDTH_MAX     = WIDTH_MAX_DEF,
    parameter logic [WORDSIZE-1:0] NEUTRAL       = NEUTRAL_DEF,
    parameter int                  SRC_TO_US     = 100000,
    parameter int                  FRAME_TO_US   = 2000,
    parameter int                  REVERT_FRAMES = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick_1us,
    input  logic                a_valid,
    output logic                a_ready,
    input  logic [2:0]          a_ch,
    input  logic [WORDSIZE-1:0] a_width,
    input  logic                a_last,
    input  logic                b_valid,
    output logic                b_ready,
    input  logic [2:0]          b_ch,
    input  logic [WORDSIZE-1:0] b_width,
    input  logic                b_last,
    output logic [WORDSIZE-1:0] pulse_width_ch1,
    output logic [WORDSIZE-1:0] pulse_width_ch2,
    output logic [WORDSIZE-1:0] pulse_width_ch3,
    output logic [WORDSIZE-1:0] pulse_width_ch4,
    output logic [WORDSIZE-1:0] pulse_width_ch5,
    output logic [WORDSIZE-1:0] pulse_width_ch6,
    output logic [WORDSIZE-1:0] pulse_width_ch7,
    output logic [WORDSIZE-1:0] pulse_width_ch8,
    output logic                data_update_flag,
    output logic                active_src,
    output logic                failsafe,
    output logic [7:0]          frame_err_cnt
);

    localparam int FTW = $clog2(FRAME_TO_US + 1);
    localparam int RCW = $clog2(REVERT_FRAMES + 1);

    sched_state_t                       state;
    src_t                               active_q;
    logic [NUM_CH-1:0][WORDSIZE-1:0]    shadow;
    logic [NUM_CH-1:0][WORDSIZE-1:0]    pw_q;
    logic [NUM_CH-1:0]                  mask_q;
    logic [FTW-1:0]                     ftmr;
    logic [RCW-1:0]                     rev_cnt;

    logic                a_healthy, b_healthy;
    logic                a_reload, b_reload;
    logic                a_acc, b_acc, w_acc;
    logic [2:0]          w_ch;
    logic [WORDSIZE-1:0] w_width;
    logic                w_last;
    src_t                w_src, cur_src;
    logic [NUM_CH-1:0]   mask_new;
    logic                frame_end, frame_tmo, frame_good, frame_bad;
    logic                active_healthy, revert_done, apply, fs_enter;

    // A gets priority in IDLE, so B's ready depends on a_valid that same clk.
    assign a_ready = !rst && ((state == IDLE) || (state == COLLECT_A));
    assign b_ready = !rst && (((state == IDLE) && !a_valid) || (state == COLLECT_B));

    always_comb begin
        a_acc = a_valid && a_ready;
        b_acc = b_valid && b_ready;
        w_acc = a_acc || b_acc;
        if (a_acc) begin
            w_ch    = a_ch;
            w_width = a_width;
            w_last  = a_last;
            w_src   = SRC_A;
        end else begin
            w_ch    = b_ch;
            w_width = b_width;
            w_last  = b_last;
            w_src   = SRC_B;
        end

        case (state)
            COLLECT_A: cur_src = SRC_A;
            COLLECT_B: cur_src = SRC_B;
            default:   cur_src = w_src;
        endcase

        // A word accepted in IDLE starts a fresh frame, so the old mask is ignored.
        mask_new   = ((state == IDLE) ? '0 : mask_q) | (NUM_CH'(1) << w_ch);
        frame_end  = w_acc && w_last;
        frame_tmo  = ((state == COLLECT_A) || (state == COLLECT_B)) && !frame_end
                     && (ftmr == FTW'(FRAME_TO_US));
        frame_good = frame_end && (&mask_new);
        frame_bad  = (frame_end && !(&mask_new)) || frame_tmo;

        active_healthy = (active_q == SRC_A) ? a_healthy : b_healthy;
        revert_done    = (cur_src == SRC_A) && (active_q == SRC_B)
                         && ((int'(rev_cnt) + 1) >= REVERT_FRAMES);
        apply          = frame_good && ((cur_src == active_q) || !active_healthy || revert_done);

        a_reload = frame_good && (cur_src == SRC_A);
        b_reload = frame_good && (cur_src == SRC_B);

        // A good frame evaluated this clk reloads its watchdog, so it vetoes failsafe.
        fs_enter = (state == IDLE) && !failsafe && !a_healthy && !b_healthy && !frame_good;
    end

    src_watchdog #(.TIMEOUT(SRC_TO_US)) u_wd_a (
        .clk      (clk),
        .rst      (rst),
        .tick_1us (tick_1us),
        .reload   (a_reload),
        .healthy  (a_healthy)
    );

    src_watchdog #(.TIMEOUT(SRC_TO_US)) u_wd_b (
        .clk      (clk),
        .rst      (rst),
        .tick_1us (tick_1us),
        .reload   (b_reload),
        .healthy  (b_healthy)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            active_q         <= SRC_A;
            shadow           <= '0;
            mask_q           <= '0;
            ftmr             <= '0;
            rev_cnt          <= '0;
            pw_q             <= {NUM_CH{NEUTRAL}};
            data_update_flag <= 1'b0;
            failsafe         <= 1'b1;
            frame_err_cnt    <= '0;
        end else begin
            data_update_flag <= 1'b0;

            // Spontaneous failover; a frame decision below overrides it.
            if ((active_q == SRC_A) && !a_healthy && b_healthy) begin
                active_q <= SRC_B;
            end

            case (state)
                IDLE, COLLECT_A, COLLECT_B: begin
                    if (w_acc) begin
                        shadow[w_ch] <= clamp_width(w_width, WIDTH_MIN, WIDTH_MAX);
                        mask_q       <= mask_new;
                    end
                    if (state == IDLE) begin
                        ftmr <= '0;
                        if (w_acc) begin
                            state <= a_acc ? COLLECT_A : COLLECT_B;
                        end
                    end else if (tick_1us) begin
                        ftmr <= ftmr + FTW'(1);
                    end
                    if (frame_good) begin
                        state <= apply ? COMMIT : IDLE;
                        if (apply) begin
                            active_q <= cur_src;
                        end
                    end else if (frame_bad) begin
                        state <= IDLE;
                        if (frame_err_cnt != 8'hFF) begin
                            frame_err_cnt <= frame_err_cnt + 8'd1;
                        end
                    end
                    if (fs_enter) begin
                        pw_q             <= {NUM_CH{NEUTRAL}};
                        data_update_flag <= 1'b1;
                        failsafe         <= 1'b1;
                    end
                end
                COMMIT: begin
                    pw_q             <= shadow;
                    data_update_flag <= 1'b1;
                    failsafe         <= 1'b0;
                    state            <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // Consecutive good A frames while running on B; any A trouble restarts the count.
            if (active_q == SRC_A) begin
                rev_cnt <= '0;
            end else if (frame_good && (cur_src == SRC_A)) begin
                rev_cnt <= revert_done ? '0 : rev_cnt + RCW'(1);
            end else if ((frame_bad && (cur_src == SRC_A)) || !a_healthy) begin
                rev_cnt <= '0;
            end
        end
    end

    assign active_src      = active_q;
    assign pulse_width_ch1 = pw_q[0];
    assign pulse_width_ch2 = pw_q[1];
    assign pulse_width_ch3 = pw_q[2];
    assign pulse_width_ch4 = pw_q[3];
    assign pulse_width_ch5 = pw_q[4];
    assign pulse_width_ch6 = pw_q[5];
    assign pulse_width_ch7 = pw_q[6];
    assign pulse_width_ch8 = pw_q[7];

endmodule

// File: tb/tb_servo_cmd_sched.sv
// Purpose: directed self-checking bench for servo_cmd_sched with shortened timeouts.
// Latency: n/a.
// Backpressure: words are held valid until the matching ready is seen.
module tb_servo_cmd_sched;
    import servo_pkg::*;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                tick_1us = 1'b0;
    logic                a_valid = 1'b0, b_valid = 1'b0;
    logic                a_last = 1'b0, b_last = 1'b0;
    logic [2:0]          a_ch = '0, b_ch = '0;
    logic [WORDSIZE-1:0] a_width = '0, b_width = '0;
    logic                a_ready, b_ready, data_update_flag, active_src, failsafe;
    logic [7:0]          frame_err_cnt;
    logic [WORDSIZE-1:0] pw [8];

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    // 300 ticks = 600 clk source timeout, 40 ticks = 80 clk frame timeout.
    servo_cmd_sched #(
        .SRC_TO_US     (300),
        .FRAME_TO_US   (40),
        .REVERT_FRAMES (3)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .tick_1us         (tick_1us),
        .a_valid          (a_valid),
        .a_ready          (a_ready),
        .a_ch             (a_ch),
        .a_width          (a_width),
        .a_last           (a_last),
        .b_valid          (b_valid),
        .b_ready          (b_ready),
        .b_ch             (b_ch),
        .b_width          (b_width),
        .b_last           (b_last),
        .pulse_width_ch1  (pw[0]),
        .pulse_width_ch2  (pw[1]),
        .pulse_width_ch3  (pw[2]),
        .pulse_width_ch4  (pw[3]),
        .pulse_width_ch5  (pw[4]),
        .pulse_width_ch6  (pw[5]),
        .pulse_width_ch7  (pw[6]),
        .pulse_width_ch8  (pw[7]),
        .data_update_flag (data_update_flag),
        .active_src       (active_src),
        .failsafe         (failsafe),
        .frame_err_cnt    (frame_err_cnt)
    );

    always #5 clk = ~clk;

    // tick_1us high every other clk.
    initial begin
        forever begin
            @(posedge clk);
            #1 tick_1us = ~tick_1us;
        end
    end

    always @(negedge clk) begin
        if (data_update_flag === 1'b1) pulses++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send_word(input bit src, input int ch, input int w, input bit last);
        bit seen;
        seen = 1'b0;
        if (!src) begin
            a_valid = 1'b1; a_ch = 3'(ch); a_width = WORDSIZE'(w); a_last = last;
        end else begin
            b_valid = 1'b1; b_ch = 3'(ch); b_width = WORDSIZE'(w); b_last = last;
        end
        for (int n = 0; n < 100 && !seen; n++) begin
            @(negedge clk);
            seen = src ? b_ready : a_ready;
        end
        @(posedge clk);
        #1;
        if (!src) a_valid = 1'b0;
        else      b_valid = 1'b0;
        chk("word_accepted", 32'(seen), 1);
    endtask

    task automatic send_frame(input bit src, input int base, input int step);
        for (int i = 0; i < 8; i++) send_word(src, i, base + step * i, i == 7);
    endtask

    task automatic wait_flag(input int max_cyc, output bit got);
        got = 1'b0;
        for (int n = 0; n < max_cyc && !got; n++) begin
            @(negedge clk);
            got = data_update_flag;
        end
    endtask

    initial begin
        bit got;
        int p0;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_a_ready", 32'(a_ready), 0);
        chk("rst_b_ready", 32'(b_ready), 0);
        chk("rst_failsafe", 32'(failsafe), 1);
        chk("rst_flag", 32'(data_update_flag), 0);
        chk("rst_active", 32'(active_src), 0);
        chk("rst_err", 32'(frame_err_cnt), 0);
        for (int i = 0; i < 8; i++) chk($sformatf("rst_w%0d", i), 32'(pw[i]), 1500);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("idle_no_pulse", pulses, 0);
        chk("idle_failsafe", 32'(failsafe), 1);
        chk("idle_a_ready", 32'(a_ready), 1);
        chk("idle_b_ready", 32'(b_ready), 1);

        // Ramp frame from A.
        p0 = pulses;
        send_frame(0, 1000, 100);
        wait_flag(20, got);
        chk("f1_update", 32'(got), 1);
        for (int i = 0; i < 8; i++) chk($sformatf("f1_w%0d", i), 32'(pw[i]), 1000 + 100 * i);
        chk("f1_failsafe", 32'(failsafe), 0);
        chk("f1_active", 32'(active_src), 0);
        repeat (3) @(negedge clk);
        chk("f1_one_pulse", pulses - p0, 1);

        // Clamping at both ends.
        send_word(0, 0, 500, 0);
        send_word(0, 1, 3000, 0);
        send_word(0, 2, 899, 0);
        send_word(0, 3, 2101, 0);
        send_word(0, 4, 2100, 0);
        send_word(0, 5, 1500, 0);
        send_word(0, 6, 1500, 0);
        send_word(0, 7, 1500, 1);
        wait_flag(20, got);
        chk("clamp_update", 32'(got), 1);
        chk("clamp_ch1", 32'(pw[0]), 900);
        chk("clamp_ch2", 32'(pw[1]), 2100);
        chk("clamp_ch3", 32'(pw[2]), 900);
        chk("clamp_ch4", 32'(pw[3]), 2100);
        chk("clamp_ch5", 32'(pw[4]), 2100);

        // Incomplete frame (ch5 missing, ch0 rewritten).
        repeat (2) @(negedge clk);
        p0 = pulses;
        send_word(0, 0, 1234, 0);
        send_word(0, 1, 1234, 0);
        send_word(0, 0, 1235, 0);
        send_word(0, 2, 1234, 0);
        send_word(0, 3, 1234, 0);
        send_word(0, 4, 1234, 0);
        send_word(0, 6, 1234, 0);
        send_word(0, 7, 1234, 1);
        repeat (5) @(negedge clk);
        chk("short_no_pulse", pulses - p0, 0);
        chk("short_err", 32'(frame_err_cnt), 1);
        chk("short_ch1_kept", 32'(pw[0]), 900);

        // Stalled frame times out; B is locked out meanwhile.
        send_word(0, 0, 1300, 0);
        @(negedge clk);
        chk("lock_b_ready", 32'(b_ready), 0);
        for (int n = 0; n < 200 && frame_err_cnt != 8'd2; n++) @(negedge clk);
        chk("stall_err", 32'(frame_err_cnt), 2);
        chk("stall_b_ready", 32'(b_ready), 1);

        // B good frame while A active and healthy only refreshes B.
        p0 = pulses;
        send_frame(1, 1800, 0);
        repeat (5) @(negedge clk);
        chk("b_refresh_no_pulse", pulses - p0, 0);
        chk("b_refresh_active", 32'(active_src), 0);

        // A goes silent -> failover to B, no commit until B's next frame.
        for (int n = 0; n < 900 && active_src !== 1'b1; n++) @(negedge clk);
        chk("failover_active", 32'(active_src), 1);
        chk("failover_no_pulse", pulses - p0, 0);
        chk("failover_failsafe", 32'(failsafe), 0);
        send_frame(1, 2000, 0);
        wait_flag(20, got);
        chk("b_commit_update", 32'(got), 1);
        chk("b_commit_ch1", 32'(pw[0]), 2000);
        chk("b_commit_ch8", 32'(pw[7]), 2000);
        chk("b_commit_active", 32'(active_src), 1);

        // Three good A frames revert to A; only the third is applied.
        repeat (2) @(negedge clk);
        p0 = pulses;
        send_frame(0, 1300, 0);
        repeat (5) @(negedge clk);
        chk("rev1_no_pulse", pulses - p0, 0);
        chk("rev1_active", 32'(active_src), 1);
        send_frame(0, 1400, 0);
        repeat (5) @(negedge clk);
        chk("rev2_no_pulse", pulses - p0, 0);
        chk("rev2_active", 32'(active_src), 1);
        send_frame(0, 1600, 0);
        wait_flag(20, got);
        chk("rev3_update", 32'(got), 1);
        chk("rev3_active", 32'(active_src), 0);
        chk("rev3_ch1", 32'(pw[0]), 1600);
        chk("rev3_ch8", 32'(pw[7]), 1600);

        // Both silent -> single neutral pulse and failsafe.
        repeat (2) @(negedge clk);
        p0 = pulses;
        for (int n = 0; n < 1500 && failsafe !== 1'b1; n++) @(negedge clk);
        chk("fs_flag", 32'(failsafe), 1);
        repeat (3) @(negedge clk);
        chk("fs_one_pulse", pulses - p0, 1);
        for (int i = 0; i < 8; i++) chk($sformatf("fs_w%0d", i), 32'(pw[i]), 1500);
        repeat (100) @(negedge clk);
        chk("fs_no_repeat", pulses - p0, 1);

        // A and B valid together in IDLE: A wins.
        @(posedge clk);
        #1;
        a_valid = 1'b1; a_ch = 3'd0; a_width = 15'd1111; a_last = 1'b0;
        b_valid = 1'b1; b_ch = 3'd0; b_width = 15'd1999; b_last = 1'b0;
        @(negedge clk);
        chk("tie_a_ready", 32'(a_ready), 1);
        chk("tie_b_ready", 32'(b_ready), 0);
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        @(negedge clk);
        chk("tie_b_locked", 32'(b_ready), 0);
        b_valid = 1'b0;
        for (int i = 1; i < 8; i++) send_word(0, i, 1200, i == 7);
        wait_flag(20, got);
        chk("tie_update", 32'(got), 1);
        chk("tie_ch1", 32'(pw[0]), 1111);
        chk("tie_ch2", 32'(pw[1]), 1200);
        chk("tie_fs_exit", 32'(failsafe), 0);

        // Reset in the middle of a frame.
        send_word(0, 0, 1700, 0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_ch1", 32'(pw[0]), 1500);
        chk("mid_rst_failsafe", 32'(failsafe), 1);
        chk("mid_rst_err", 32'(frame_err_cnt), 0);
        chk("mid_rst_active", 32'(active_src), 0);
        chk("mid_rst_a_ready", 32'(a_ready), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_rst_a_ready", 32'(a_ready), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
